hall_call_dispatcher: RTL and testbench



---
 rtl/sys_pkg.sv | 25 ++
 rtl/nearest_call_finder.sv | 41 ++++
 rtl/hall_call_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared constants, types and distance helper for the hall call dispatcher.
package sys_pkg;
    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        ASSIGNED = 1'b1
    } elev_state_e;

    typedef struct packed {
        logic [FLOOR_W-1:0] floor;
        logic               dir_up;
    } call_t;

    // Unsigned |a - b| with one extra bit so the subtraction never wraps.
    function automatic logic [FLOOR_W:0] floor_dist(input logic [FLOOR_W-1:0] a,
                                                   input logic [FLOOR_W-1:0] b);
        logic [FLOOR_W:0] a_ext;
        logic [FLOOR_W:0] b_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        return (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
    endfunction
endpackage

// File: rtl/nearest_call_finder.sv
// Combinational search for the candidate call closest to one elevator.
module nearest_call_finder
    import sys_pkg::*;
(
    input  logic [FLOOR_W-1:0]    location,
    input  logic [NUM_FLOORS-1:0] up_mask,
    input  logic [NUM_FLOORS-1:0] down_mask,
    output logic                  found,
    output call_t                 best
);

    logic [FLOOR_W:0]   best_dist_s;
    logic [FLOOR_W:0]   dist_s;
    logic [FLOOR_W-1:0] idx_s;

    // Scan low to high, up before down; strict '<' keeps the earliest entry on a tie.
    always_comb begin
        found       = 1'b0;
        best        = '0;
        best_dist_s = '0;
        dist_s      = '0;
        idx_s       = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            idx_s  = FLOOR_W'(i);
            dist_s = floor_dist(location, idx_s);
            if (up_mask[i] && (!found || (dist_s < best_dist_s))) begin
                found       = 1'b1;
                best.floor  = idx_s;
                best.dir_up = 1'b1;
                best_dist_s = dist_s;
            end
            if (down_mask[i] && (!found || (dist_s < best_dist_s))) begin
                found       = 1'b1;
                best.floor  = idx_s;
                best.dir_up = 1'b0;
                best_dist_s = dist_s;
            end
        end
    end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Latches hall calls, hands each one to a free elevator and retires it on arrival.
module hall_call_dispatcher
    import sys_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_FLOORS-1:0]   up_call,
    input  logic [NUM_FLOORS-1:0]   down_call,
    input  logic [2*FLOOR_W-1:0]    elevators_location,
    input  logic [1:0]              doors_status,
    output logic [2*FLOOR_W-1:0]    target_floor,
    output logic [1:0]              target_valid,
    output logic [NUM_FLOORS-1:0]   pending_up,
    output logic [NUM_FLOORS-1:0]   pending_down
);

    // No up button on the top floor, no down button on the ground floor.
    localparam logic [NUM_FLOORS-1:0] UP_VALID   = ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
    localparam logic [NUM_FLOORS-1:0] DOWN_VALID = ~NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] pending_up_q,    pending_up_d;
    logic [NUM_FLOORS-1:0] pending_down_q,  pending_down_d;
    logic [NUM_FLOORS-1:0] assigned_up_q,   assigned_up_d;
    logic [NUM_FLOORS-1:0] assigned_down_q, assigned_down_d;
    elev_state_e           state_q  [2];
    elev_state_e           state_d  [2];
    logic [FLOOR_W-1:0]    target_q [2];
    logic [FLOOR_W-1:0]    target_d [2];
    logic                  dir_up_q [2];
    logic                  dir_up_d [2];

    logic [FLOOR_W-1:0]    loc_s    [2];
    logic                  loc_ok_s [2];
    logic                  clear_s  [2];
    logic                  found_s  [2];
    call_t                 best_s   [2];
    logic                  grant_s  [2];
    logic                  grant_e1_s;
    logic                  grant_e2_s;
    logic [NUM_FLOORS-1:0] cand_up_s;
    logic [NUM_FLOORS-1:0] cand_down_s;
    logic [NUM_FLOORS-1:0] grant_up_s;
    logic [NUM_FLOORS-1:0] grant_down_s;
    logic [NUM_FLOORS-1:0] clr_up_s;
    logic [NUM_FLOORS-1:0] clr_down_s;

    assign cand_up_s   = pending_up_q   & ~assigned_up_q;
    assign cand_down_s = pending_down_q & ~assigned_down_q;

    // Per-elevator location decode and arrival detection (door bit 0 means open).
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            loc_s[e]    = elevators_location[e*FLOOR_W +: FLOOR_W];
            loc_ok_s[e] = ({1'b0, loc_s[e]} < (FLOOR_W+1)'(NUM_FLOORS));
            clear_s[e]  = (state_q[e] == ASSIGNED) && loc_ok_s[e] &&
                          (loc_s[e] == target_q[e]) && !doors_status[e];
        end
    end

    nearest_call_finder u_finder_e1 (
        .location  (loc_s[0]),
        .up_mask   (cand_up_s),
        .down_mask (cand_down_s),
        .found     (found_s[0]),
        .best      (best_s[0])
    );

    nearest_call_finder u_finder_e2 (
        .location  (loc_s[1]),
        .up_mask   (cand_up_s),
        .down_mask (cand_down_s),
        .found     (found_s[1]),
        .best      (best_s[1])
    );

    // E1 has priority, so a single call can never reach both elevators in one cycle.
    assign grant_e1_s = (state_q[0] == IDLE) && loc_ok_s[0] && found_s[0];
    assign grant_e2_s = !grant_e1_s && (state_q[1] == IDLE) && loc_ok_s[1] && found_s[1];
    assign grant_s[0] = grant_e1_s;
    assign grant_s[1] = grant_e2_s;

    // Elevator FSM next state and target capture.
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            state_d[e]  = state_q[e];
            target_d[e] = target_q[e];
            dir_up_d[e] = dir_up_q[e];
            case (state_q[e])
                IDLE: begin
                    if (grant_s[e]) begin
                        state_d[e]  = ASSIGNED;
                        target_d[e] = best_s[e].floor;
                        dir_up_d[e] = best_s[e].dir_up;
                    end else begin
                        state_d[e]  = IDLE;
                    end
                end
                ASSIGNED: begin
                    if (clear_s[e]) begin
                        state_d[e] = IDLE;
                    end else begin
                        state_d[e] = ASSIGNED;
                    end
                end
                default: state_d[e] = IDLE;
            endcase
        end
    end

    // Call bookkeeping; a clear overrides a simultaneous press of the same call.
    always_comb begin
        grant_up_s   = '0;
        grant_down_s = '0;
        clr_up_s     = '0;
        clr_down_s   = '0;
        for (int e = 0; e < 2; e++) begin
            if (grant_s[e]) begin
                if (best_s[e].dir_up) begin
                    grant_up_s[best_s[e].floor] = 1'b1;
                end else begin
                    grant_down_s[best_s[e].floor] = 1'b1;
                end
            end
            if (clear_s[e]) begin
                if (dir_up_q[e]) begin
                    clr_up_s[target_q[e]] = 1'b1;
                end else begin
                    clr_down_s[target_q[e]] = 1'b1;
                end
            end
        end
        pending_up_d    = (pending_up_q   | (up_call   & UP_VALID))   & ~clr_up_s;
        pending_down_d  = (pending_down_q | (down_call & DOWN_VALID)) & ~clr_down_s;
        assigned_up_d   = (assigned_up_q   | grant_up_s)   & ~clr_up_s;
        assigned_down_d = (assigned_down_q | grant_down_s) & ~clr_down_s;
    end

    // State registers; reset drops every call, assignment and target at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_up_q    <= '0;
            pending_down_q  <= '0;
            assigned_up_q   <= '0;
            assigned_down_q <= '0;
            for (int e = 0; e < 2; e++) begin
                state_q[e]  <= IDLE;
                target_q[e] <= '0;
                dir_up_q[e] <= 1'b0;
            end
        end else begin
            pending_up_q    <= pending_up_d;
            pending_down_q  <= pending_down_d;
            assigned_up_q   <= assigned_up_d;
            assigned_down_q <= assigned_down_d;
            for (int e = 0; e < 2; e++) begin
                state_q[e]  <= state_d[e];
                target_q[e] <= target_d[e];
                dir_up_q[e] <= dir_up_d[e];
            end
        end
    end

    assign target_floor = {target_q[1], target_q[0]};
    assign target_valid = {(state_q[1] == ASSIGNED), (state_q[0] == ASSIGNED)};
    assign pending_up   = pending_up_q;
    assign pending_down = pending_down_q;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed scoreboard bench: stimulus queues expected snapshots, a monitor compares them.
module tb_hall_call_dispatcher;
    import sys_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] up_call;
    logic [7:0] down_call;
    logic [5:0] elevators_location;
    logic [1:0] doors_status;
    logic [5:0] target_floor;
    logic [1:0] target_valid;
    logic [7:0] pending_up;
    logic [7:0] pending_down;

    typedef struct {
        int         cyc;
        string      name;
        logic [5:0] tf;
        logic [1:0] tv;
        logic [7:0] pu;
        logic [7:0] pd;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   stim_done = 1'b0;

    hall_call_dispatcher dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .up_call            (up_call),
        .down_call          (down_call),
        .elevators_location (elevators_location),
        .doors_status       (doors_status),
        .target_floor       (target_floor),
        .target_valid       (target_valid),
        .pending_up         (pending_up),
        .pending_down       (pending_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // dly < 0 marks a check taken 1 time unit after rst_n falls, independent of clk.
    task automatic expect_at(input int dly, input string name, input logic [5:0] tf,
                             input logic [1:0] tv, input logic [7:0] pu, input logic [7:0] pd);
        exp_t e;
        e.cyc  = (dly < 0) ? -1 : cyc + dly;
        e.name = name;
        e.tf   = tf;
        e.tv   = tv;
        e.pu   = pu;
        e.pd   = pd;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [7:0] up, input logic [7:0] dn, input logic [2:0] l2,
                         input logic [2:0] l1, input logic [1:0] dr);
        up_call            = up;
        down_call          = dn;
        elevators_location = {l2, l1};
        doors_status       = dr;
    endtask

    task automatic check(input exp_t e);
        n_checks++;
        if (target_floor !== e.tf || target_valid !== e.tv ||
            pending_up !== e.pu || pending_down !== e.pd) begin
            n_fail++;
            $display("FAIL %s: got tf=%o tv=%b pu=%h pd=%h, expected tf=%o tv=%b pu=%h pd=%h",
                     e.name, target_floor, target_valid, pending_up, pending_down,
                     e.tf, e.tv, e.pu, e.pd);
        end
    endtask

    // target_floor literals are octal: first digit E2, second digit E1.
    initial begin : stim
        drive(8'h00, 8'h00, 3'd5, 3'd0, 2'b11);
        rst_n = 1'b1;
        expect_at(-1, "reset_state", 6'o00, 2'b00, 8'h00, 8'h00);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        drive(8'h08, 8'h00, 3'd5, 3'd0, 2'b11);
        expect_at(1, "latch_up3",    6'o00, 2'b00, 8'h08, 8'h00);
        expect_at(2, "assign_e1_f3", 6'o03, 2'b01, 8'h08, 8'h00);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd5, 3'd0, 2'b11);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd5, 3'd3, 2'b10);
        expect_at(1, "serve_e1_f3",  6'o03, 2'b00, 8'h00, 8'h00);

        @(negedge clk);
        drive(8'h02, 8'h40, 3'd7, 3'd0, 2'b11);
        expect_at(1, "latch_two",     6'o03, 2'b00, 8'h02, 8'h40);
        expect_at(2, "e1_nearest_f1", 6'o01, 2'b01, 8'h02, 8'h40);
        expect_at(3, "e2_down_f6",    6'o61, 2'b11, 8'h02, 8'h40);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd7, 3'd0, 2'b11);
        @(negedge clk);
        @(negedge clk);
        drive(8'h02, 8'h00, 3'd6, 3'd1, 2'b00);
        expect_at(1, "serve_both_clear_wins", 6'o61, 2'b00, 8'h00, 8'h00);

        @(negedge clk);
        drive(8'h44, 8'h02, 3'd7, 3'd4, 2'b11);
        expect_at(1, "latch_three",      6'o61, 2'b00, 8'h44, 8'h02);
        expect_at(2, "e1_tie_low_floor", 6'o62, 2'b01, 8'h44, 8'h02);
        expect_at(3, "e2_nearest_left",  6'o62, 2'b11, 8'h44, 8'h02);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd7, 3'd4, 2'b11);
        @(negedge clk);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd6, 3'd4, 2'b01);
        expect_at(1, "serve_e2_f6",   6'o62, 2'b01, 8'h04, 8'h02);
        expect_at(2, "e2_regrant_f1", 6'o12, 2'b11, 8'h04, 8'h02);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd6, 3'd4, 2'b11);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd1, 3'd4, 2'b01);
        expect_at(1, "serve_e2_f1",   6'o12, 2'b01, 8'h04, 8'h00);

        @(negedge clk);
        drive(8'h84, 8'h01, 3'd1, 3'd4, 2'b11);
        expect_at(1, "mask_merge",   6'o12, 2'b01, 8'h04, 8'h00);
        expect_at(2, "no_dup_grant", 6'o12, 2'b01, 8'h04, 8'h00);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd1, 3'd4, 2'b11);
        @(negedge clk);

        @(negedge clk);
        drive(8'h00, 8'h20, 3'd1, 3'd4, 2'b11);
        expect_at(1, "latch_d5",    6'o12, 2'b01, 8'h04, 8'h20);
        expect_at(2, "e2_grant_f5", 6'o52, 2'b11, 8'h04, 8'h20);
        @(negedge clk);
        drive(8'h00, 8'h00, 3'd1, 3'd4, 2'b11);
        @(negedge clk);

        @(posedge clk);
        #2;
        expect_at(-1, "async_reset", 6'o00, 2'b00, 8'h00, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(1, "post_reset_idle", 6'o00, 2'b00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin : monitor
        exp_t e;
        while (!stim_done) begin
            @(negedge clk or negedge rst_n);
            if (sb.size() > 0 && sb[0].cyc < 0) begin
                #1;
                e = sb.pop_front();
                check(e);
            end else begin
                while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    check(e);
                end
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, was due at cycle %0d", e.name, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
